chord_note_player: RTL and testbench

- Consumer end of the note handshake driven by the song reader.
- On each new_note pulse it latches up to four chord notes with their metadata, the voice count and the duration.
- It drives per-voice note and enable outputs to the note generators, then counts beat ticks for the duration and pulses note_done.
- Sits between the song reader and the four note generators / harmonic mixer.

---
 rtl/chord_note_player_pkg.sv | 26 ++
 rtl/chord_voice_latch.sv | 51 +++++
 rtl/chord_note_player.sv | 187 ++++++++++++++++++
 tb/tb_chord_note_player.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chord_note_player_pkg.sv
// -----------------------------------------------------------------------------
// chord_note_player_pkg
// Shared constants and state encoding for the chord note player and its
// per-voice latch.
//   CNP_NOTE_WIDTH     default width of a note index (0 is a rest)
//   CNP_DURATION_WIDTH default width of a note duration in beats
//   CNP_META_WIDTH     default width of per-note harmonic metadata
//   CNP_NUM_VOICES     number of chord voices
//   CNP_REST           note value that means "rest"
//   cnp_state_e        player state: CNP_IDLE, CNP_HOLD, CNP_DONE
// -----------------------------------------------------------------------------
package chord_note_player_pkg;

  localparam int CNP_NOTE_WIDTH     = 6;
  localparam int CNP_DURATION_WIDTH = 6;
  localparam int CNP_META_WIDTH     = 3;
  localparam int CNP_NUM_VOICES     = 4;
  localparam int CNP_REST           = 0;

  typedef enum logic [1:0] {
    CNP_IDLE = 2'd0,
    CNP_HOLD = 2'd1,
    CNP_DONE = 2'd2
  } cnp_state_e;

endpackage

// File: rtl/chord_voice_latch.sv
// -----------------------------------------------------------------------------
// chord_voice_latch
// Holds one chord voice (note + harmonic metadata) and reports whether that
// voice is in use for the currently latched chord.
//   clk, reset_n  clock, asynchronous active-low reset
//   latch_i       capture note_i/meta_i this cycle
//   note_i        incoming note index
//   meta_i        incoming harmonic metadata
//   num_notes_i   latched voice count minus one
//   note_o        held note index
//   meta_o        held metadata
//   en_o          voice is within the chord and is not a rest
// -----------------------------------------------------------------------------
module chord_voice_latch
  import chord_note_player_pkg::*;
#(
  parameter int         NOTE_WIDTH = CNP_NOTE_WIDTH,
  parameter int         META_WIDTH = CNP_META_WIDTH,
  parameter logic [1:0] VOICE_IDX  = 2'd0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  latch_i,
  input  logic [NOTE_WIDTH-1:0] note_i,
  input  logic [META_WIDTH-1:0] meta_i,
  input  logic [1:0]            num_notes_i,
  output logic [NOTE_WIDTH-1:0] note_o,
  output logic [META_WIDTH-1:0] meta_o,
  output logic                  en_o
);

  logic [NOTE_WIDTH-1:0] note_q;
  logic [META_WIDTH-1:0] meta_q;

  // NOTE: these data registers are reset (unlike a plain datapath store) so
  // the note generators see a rest with zero metadata straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      note_q <= '0;
      meta_q <= '0;
    end else if (latch_i) begin
      note_q <= note_i;
      meta_q <= meta_i;
    end
  end

  assign note_o = note_q;
  assign meta_o = meta_q;
  assign en_o   = (num_notes_i >= VOICE_IDX) && (note_q != NOTE_WIDTH'(CNP_REST));

endmodule

// File: rtl/chord_note_player.sv
// -----------------------------------------------------------------------------
// chord_note_player
// Consumer end of the song reader's note handshake. On new_note it latches up
// to four chord notes with metadata, the voice count and the duration, drives
// the four note generators, counts beats while playing and pulses note_done
// one cycle after the final beat.
//
// Optional build macro: CHORD_RELEASE_GAP_EN -- when defined, for durations of
// two or more beats all voices are muted during the final beat so repeated
// notes are articulated. note_done timing is not affected.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   play                      global play/pause; low freezes playback
//   beat                      one-cycle beat tick
//   new_note                  one-cycle pulse; chord inputs valid this cycle
//   note1..note4              chord notes (0 = rest)
//   metadata1..metadata4      harmonic metadata per note
//   num_notes                 voices used minus one
//   duration                  note length in beats
//   voice_note1..voice_note4  latched notes to the generators
//   voice_meta1..voice_meta4  latched metadata
//   voice_en                  per-voice enable (bit0 = voice1)
//   load                      one-cycle pulse: generators restart phase
//   busy                      a note is being held
//   note_done                 one-cycle pulse at note end
// -----------------------------------------------------------------------------
module chord_note_player
  import chord_note_player_pkg::*;
#(
  parameter int NOTE_WIDTH     = CNP_NOTE_WIDTH,
  parameter int DURATION_WIDTH = CNP_DURATION_WIDTH,
  parameter int META_WIDTH     = CNP_META_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      play,
  input  logic                      beat,
  input  logic                      new_note,
  input  logic [NOTE_WIDTH-1:0]     note1,
  input  logic [NOTE_WIDTH-1:0]     note2,
  input  logic [NOTE_WIDTH-1:0]     note3,
  input  logic [NOTE_WIDTH-1:0]     note4,
  input  logic [META_WIDTH-1:0]     metadata1,
  input  logic [META_WIDTH-1:0]     metadata2,
  input  logic [META_WIDTH-1:0]     metadata3,
  input  logic [META_WIDTH-1:0]     metadata4,
  input  logic [1:0]                num_notes,
  input  logic [DURATION_WIDTH-1:0] duration,
  output logic [NOTE_WIDTH-1:0]     voice_note1,
  output logic [NOTE_WIDTH-1:0]     voice_note2,
  output logic [NOTE_WIDTH-1:0]     voice_note3,
  output logic [NOTE_WIDTH-1:0]     voice_note4,
  output logic [META_WIDTH-1:0]     voice_meta1,
  output logic [META_WIDTH-1:0]     voice_meta2,
  output logic [META_WIDTH-1:0]     voice_meta3,
  output logic [META_WIDTH-1:0]     voice_meta4,
  output logic [3:0]                voice_en,
  output logic                      load,
  output logic                      busy,
  output logic                      note_done
);

  cnp_state_e                state_q, state_d;
  logic [DURATION_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [DURATION_WIDTH-1:0] duration_q;
  logic [1:0]                num_notes_q;
  logic                      load_q, load_d;
  logic                      latch;
  logic                      last_beat;
  logic                      mute;

  logic [NOTE_WIDTH-1:0] note_in   [CNP_NUM_VOICES];
  logic [META_WIDTH-1:0] meta_in   [CNP_NUM_VOICES];
  logic [NOTE_WIDTH-1:0] note_out  [CNP_NUM_VOICES];
  logic [META_WIDTH-1:0] meta_out  [CNP_NUM_VOICES];
  logic [3:0]            voice_use;

  assign note_in[0] = note1;
  assign note_in[1] = note2;
  assign note_in[2] = note3;
  assign note_in[3] = note4;
  assign meta_in[0] = metadata1;
  assign meta_in[1] = metadata2;
  assign meta_in[2] = metadata3;
  assign meta_in[3] = metadata4;

  // The counter only ever reaches duration-1, so it cannot wrap. A zero
  // duration is caught separately before this compare matters.
  assign last_beat = (beat_cnt_q == duration_q - DURATION_WIDTH'(1));

  // ---------------------------------------------------------------------------
  // Next-state logic. new_note wins in every state: it relatches and restarts
  // the count, so a beat arriving in the same cycle is never counted and an
  // aborted note never reaches DONE.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    load_d     = 1'b0;
    latch      = 1'b0;
    if (new_note) begin
      latch      = 1'b1;
      load_d     = 1'b1;
      beat_cnt_d = '0;
      state_d    = CNP_HOLD;
    end else begin
      unique case (state_q)
        CNP_IDLE: ;
        CNP_HOLD: begin
          if (duration_q == '0) begin
            state_d = CNP_DONE;
          end else if (beat && play) begin
            if (last_beat) state_d = CNP_DONE;
            else           beat_cnt_d = beat_cnt_q + DURATION_WIDTH'(1);
          end
        end
        CNP_DONE: state_d = CNP_IDLE;
        default:  state_d = CNP_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CNP_IDLE;
      beat_cnt_q  <= '0;
      duration_q  <= '0;
      num_notes_q <= '0;
      load_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      load_q     <= load_d;
      if (latch) begin
        duration_q  <= duration;
        num_notes_q <= num_notes;
      end
    end
  end

  for (genvar g = 0; g < CNP_NUM_VOICES; g++) begin : g_voice
    chord_voice_latch #(
      .NOTE_WIDTH (NOTE_WIDTH),
      .META_WIDTH (META_WIDTH),
      .VOICE_IDX  (2'(g))
    ) u_latch (
      .clk         (clk),
      .reset_n     (reset_n),
      .latch_i     (latch),
      .note_i      (note_in[g]),
      .meta_i      (meta_in[g]),
      .num_notes_i (num_notes_q),
      .note_o      (note_out[g]),
      .meta_o      (meta_out[g]),
      .en_o        (voice_use[g])
    );
  end

`ifdef CHORD_RELEASE_GAP_EN
  // Silence the final beat of notes two beats or longer.
  assign mute = (duration_q >= DURATION_WIDTH'(2)) && last_beat;
`else
  assign mute = 1'b0;
`endif

  // Voices sound only while holding, playing and with a non-zero duration.
  assign voice_en  = (state_q == CNP_HOLD && play && duration_q != '0 && !mute)
                     ? voice_use : 4'b0000;
  assign load      = load_q;
  assign busy      = (state_q == CNP_HOLD);
  assign note_done = (state_q == CNP_DONE);

  assign voice_note1 = note_out[0];
  assign voice_note2 = note_out[1];
  assign voice_note3 = note_out[2];
  assign voice_note4 = note_out[3];
  assign voice_meta1 = meta_out[0];
  assign voice_meta2 = meta_out[1];
  assign voice_meta3 = meta_out[2];
  assign voice_meta4 = meta_out[3];

endmodule

// File: tb/tb_chord_note_player.sv
// -----------------------------------------------------------------------------
// tb_chord_note_player
// Self-checking bench for chord_note_player: directed scenarios followed by
// randomized traffic, compared every cycle against a note-level model that
// tracks the number of beats still owed for the current note.
// Honours CHORD_RELEASE_GAP_EN in the model when the build defines it.
// -----------------------------------------------------------------------------
module tb_chord_note_player;

  localparam int NW = 6;
  localparam int DW = 6;
  localparam int MW = 3;

`ifdef CHORD_RELEASE_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          play;
  logic          beat;
  logic          new_note;
  logic [NW-1:0] note_in [4];
  logic [MW-1:0] meta_in [4];
  logic [1:0]    num_notes;
  logic [DW-1:0] duration;
  logic [NW-1:0] vn [4];
  logic [MW-1:0] vm [4];
  logic [3:0]    voice_en;
  logic          load;
  logic          busy;
  logic          note_done;

  always #5 clk = ~clk;

  chord_note_player dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .play        (play),
    .beat        (beat),
    .new_note    (new_note),
    .note1       (note_in[0]),
    .note2       (note_in[1]),
    .note3       (note_in[2]),
    .note4       (note_in[3]),
    .metadata1   (meta_in[0]),
    .metadata2   (meta_in[1]),
    .metadata3   (meta_in[2]),
    .metadata4   (meta_in[3]),
    .num_notes   (num_notes),
    .duration    (duration),
    .voice_note1 (vn[0]),
    .voice_note2 (vn[1]),
    .voice_note3 (vn[2]),
    .voice_note4 (vn[3]),
    .voice_meta1 (vm[0]),
    .voice_meta2 (vm[1]),
    .voice_meta3 (vm[2]),
    .voice_meta4 (vm[3]),
    .voice_en    (voice_en),
    .load        (load),
    .busy        (busy),
    .note_done   (note_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model (beats still owed per note) -------------
  bit m_holding, m_done, m_load;
  int m_left, m_dur, m_nv;
  int m_note [4];
  int m_meta [4];

  function automatic void model_reset();
    m_holding = 0; m_done = 0; m_load = 0;
    m_left = 0; m_dur = 0; m_nv = 0;
    for (int i = 0; i < 4; i++) begin
      m_note[i] = 0;
      m_meta[i] = 0;
    end
  endfunction

  function automatic logic [3:0] exp_en();
    logic [3:0] e = 4'b0000;
    bit final_gap = GAP_EN && (m_dur >= 2) && (m_left == 1);
    if (m_holding && play && m_dur > 0 && !final_gap)
      for (int i = 0; i < 4; i++)
        e[i] = (i <= m_nv) && (m_note[i] != 0);
    return e;
  endfunction

  // Advance the model across one clock edge using the inputs held this cycle.
  function automatic void model_edge();
    bit done_next = 0;
    bit load_next = 0;
    if (new_note) begin
      for (int i = 0; i < 4; i++) begin
        m_note[i] = int'(note_in[i]);
        m_meta[i] = int'(meta_in[i]);
      end
      m_nv = int'(num_notes);
      m_dur = int'(duration);
      m_left = m_dur;
      m_holding = 1;
      load_next = 1;
    end else if (m_holding) begin
      if (m_left == 0) begin
        m_holding = 0;
        done_next = 1;
      end else if (beat && play) begin
        m_left--;
        if (m_left == 0) begin
          m_holding = 0;
          done_next = 1;
        end
      end
    end
    m_done = done_next;
    m_load = load_next;
  endfunction

  task automatic compare_all();
    check("voice_en", 32'(voice_en), 32'(exp_en()));
    check("busy", 32'(busy), 32'(m_holding));
    check("note_done", 32'(note_done), 32'(m_done));
    check("load", 32'(load), 32'(m_load));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("voice_note%0d", i + 1), 32'(vn[i]), 32'(m_note[i]));
      check($sformatf("voice_meta%0d", i + 1), 32'(vm[i]), 32'(m_meta[i]));
    end
  endtask

  // ---------------- stimulus helpers ----------------------------------------
  task automatic step(input bit nn, input bit bt);
    @(negedge clk);
    new_note = nn;
    beat     = bt;
    #1 compare_all();
    @(posedge clk);
    model_edge();
  endtask

  task automatic send(input int n1, input int n2, input int n3, input int n4,
                      input int nv, input int dur, input bit bt);
    note_in[0] = NW'(n1); note_in[1] = NW'(n2);
    note_in[2] = NW'(n3); note_in[3] = NW'(n4);
    for (int i = 0; i < 4; i++) meta_in[i] = MW'($urandom_range(0, 7));
    num_notes = 2'(nv);
    duration  = DW'(dur);
    step(1'b1, bt);
  endtask

  // Run idle cycles, with a beat on the last cycle of every period (0 = none).
  task automatic run(input int cycles, input int period);
    for (int c = 0; c < cycles; c++)
      step(1'b0, (period > 0) && (c % period == period - 1));
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_voice_en", 32'(voice_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_note_done", 32'(note_done), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_voice_note1", 32'(vn[0]), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; play = 1'b1; beat = 1'b0; new_note = 1'b0;
    num_notes = '0; duration = '0;
    for (int i = 0; i < 4; i++) begin
      note_in[i] = '0;
      meta_in[i] = '0;
    end
    model_reset();
    #12 compare_all();
    @(negedge clk);
    reset_n = 1'b1;

    // Single note, three beats.
    send(20, 0, 0, 0, 0, 3, 1'b0);
    run(35, 10);
    // Chord with a rest in voice 3.
    send(20, 24, 0, 31, 3, 2, 1'b0);
    run(25, 10);
    // Pause for five beats after the first.
    send(12, 13, 14, 15, 2, 4, 1'b0);
    run(10, 10);
    play = 1'b0;
    run(50, 10);
    play = 1'b1;
    run(40, 10);
    // Abort after two beats with a one-beat note.
    send(5, 6, 7, 8, 1, 5, 1'b0);
    run(20, 10);
    send(40, 0, 0, 0, 0, 1, 1'b0);
    run(15, 10);
    // Zero duration.
    send(9, 10, 11, 12, 3, 0, 1'b0);
    run(5, 0);
    // Beat coinciding with new_note in IDLE is not counted.
    send(33, 0, 0, 0, 0, 2, 1'b1);
    run(25, 10);
    // Asynchronous reset while holding.
    send(17, 18, 0, 0, 1, 5, 1'b0);
    run(5, 0);
    async_reset();
    run(5, 0);
    // Release-gap shapes (plain hold when the gap is not built in).
    send(21, 22, 23, 24, 3, 3, 1'b0);
    run(35, 10);
    send(25, 0, 0, 0, 0, 1, 1'b0);
    run(15, 10);
    // Maximum duration.
    send(63, 1, 2, 3, 3, 63, 1'b0);
    run(66, 1);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      bit nn = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < 4; i++) begin
        note_in[i] = ($urandom_range(0, 3) == 0) ? NW'(0) : NW'($urandom_range(1, 63));
        meta_in[i] = MW'($urandom_range(0, 7));
      end
      num_notes = 2'($urandom_range(0, 3));
      duration  = ($urandom_range(0, 15) == 0) ? DW'($urandom_range(0, 63))
                                                : DW'($urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0) play = ~play;
      step(nn, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
